// File: rtl/barrel_sched_pkg.sv
// Shared types for the barrel thread scheduler: FSM states and the default thread index type.
// Purely declarative; no logic lives here.
package barrel_sched_pkg;

  localparam int DEF_NUM_THREADS = 16;
  localparam int TID_W           = $clog2(DEF_NUM_THREADS);
  localparam int BOOT_CNT_W      = 8;

  typedef logic [TID_W-1:0] tid_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1
  } sched_state_e;

endpackage

// File: rtl/rr_next_eligible.sv
// Combinational circular priority finder: first set bit of eligible after start, wrapping back to start.
// Zero latency; found is low when the mask is empty.
module rr_next_eligible #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] index
);

  logic [W-1:0] cand;

  // Offset N wraps to start itself, so the current thread is the last candidate.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = start + W'(i);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/barrel_thread_scheduler.sv
// Picks the thread issuing into the barrel pipeline each cycle, with per-thread blocking.
// Issue outputs are registered one edge after the decision; i_stall freezes issue state only.
module barrel_thread_scheduler
  import barrel_sched_pkg::*;
#(
  parameter logic [31:0] ID            = 32'h0,
  parameter int          NUM_THREADS   = 16,
  parameter bit          STRICT_BARREL = 1'b1,
  parameter int          BOOT_CYCLES   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_THREADS-1:0]         i_thread_enable,
  input  logic                           i_stall,
  input  logic                           i_block_valid,
  input  logic [$clog2(NUM_THREADS)-1:0] i_block_index,
  input  logic                           i_wake_valid,
  input  logic [$clog2(NUM_THREADS)-1:0] i_wake_index,
  output logic                           o_issue_valid,
  output logic [$clog2(NUM_THREADS)-1:0] o_thread_index,
  output logic [31:0]                    o_hartid,
  output logic [NUM_THREADS-1:0]         o_blocked_mask,
  output logic                           o_idle
);

  localparam int IDX_W = $clog2(NUM_THREADS);

  sched_state_e           state;
  logic [BOOT_CNT_W-1:0]  boot_cnt;
  logic [IDX_W-1:0]       ptr;
  logic [NUM_THREADS-1:0] blocked;
  logic [NUM_THREADS-1:0] block_hot;
  logic [NUM_THREADS-1:0] wake_hot;
  logic [NUM_THREADS-1:0] eligible;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_vld;
  logic                   sel_move;

  always_comb begin
    block_hot = '0;
    wake_hot  = '0;
    block_hot[i_block_index] = i_block_valid;
    wake_hot[i_wake_index]   = i_wake_valid;
  end

  // A block landing this cycle already excludes the thread; a wake only counts next cycle.
  assign eligible       = i_thread_enable & ~blocked & ~block_hot;
  assign o_blocked_mask = blocked;

  if (STRICT_BARREL) begin : g_strict
    logic [IDX_W-1:0] nxt;
    assign nxt      = ptr + IDX_W'(1);
    assign sel_idx  = nxt;
    assign sel_vld  = eligible[nxt];
    assign sel_move = 1'b1;
  end else begin : g_skip
    logic             found;
    logic [IDX_W-1:0] first;
    rr_next_eligible #(
      .N (NUM_THREADS),
      .W (IDX_W)
    ) u_find (
      .eligible (eligible),
      .start    (ptr),
      .found    (found),
      .index    (first)
    );
    assign sel_idx  = found ? first : ptr;
    assign sel_vld  = found;
    assign sel_move = found;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= BOOT;
      boot_cnt       <= '0;
      ptr            <= IDX_W'(NUM_THREADS - 1);
      blocked        <= '0;
      o_issue_valid  <= 1'b0;
      o_thread_index <= '0;
      o_hartid       <= ID;
      o_idle         <= 1'b1;
    end else begin
      blocked <= (blocked | block_hot) & ~wake_hot;
      case (state)
        BOOT: begin
          o_issue_valid <= 1'b0;
          o_idle        <= 1'b1;
          if (boot_cnt == BOOT_CNT_W'(BOOT_CYCLES)) state <= RUN;
          else boot_cnt <= boot_cnt + 1'b1;
        end
        RUN: begin
          o_idle <= ~|eligible;
          if (!i_stall) begin
            o_issue_valid <= sel_vld;
            if (sel_move) begin
              ptr            <= sel_idx;
              o_thread_index <= sel_idx;
              o_hartid       <= ID + 32'(sel_idx);
            end
          end
        end
        default: begin
          state         <= BOOT;
          boot_cnt      <= '0;
          o_issue_valid <= 1'b0;
          o_idle        <= 1'b1;
        end
      endcase
    end
  end

  always @(posedge clk) begin
    if (!reset && i_block_valid && i_wake_valid)
      assert (i_block_index != i_wake_index)
        else $warning("block and wake on thread %0d in the same cycle; wake wins", i_wake_index);
  end

endmodule

// File: doc/barrel_thread_scheduler.md
Name: barrel_thread_scheduler

Overview:
Selects which hardware thread issues into the barrel pipeline each cycle. It rotates round-robin over NUM_THREADS contexts and skips disabled or blocked threads, or inserts bubbles for them in strict mode. It tracks per-thread blocking on long-latency operations. Its registered thread index and hart ID drive the fetch stage and the immediate/hart-ID select path downstream.

Parameters:
ID, 32'h0, base hart ID; o_hartid = ID + thread index
NUM_THREADS, 16, number of hardware threads; power of 2, >= 2
STRICT_BARREL, 1, 1 = fixed rotation with bubbles; 0 = skip to next eligible thread
BOOT_CYCLES, 4, cycles issue is held off after reset; 0 allowed, range 0..255

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
i_thread_enable  in  NUM_THREADS  per-thread enable mask
i_stall  in  1  pipeline freeze; hold issue state
i_block_valid  in  1  mark thread i_block_index blocked
i_block_index  in  $clog2(NUM_THREADS)  thread to block
i_wake_valid  in  1  mark thread i_wake_index unblocked
i_wake_index  in  $clog2(NUM_THREADS)  thread to wake
o_issue_valid  out  1  o_thread_index is a real issue slot (0 = bubble)
o_thread_index  out  $clog2(NUM_THREADS)  selected thread
o_hartid  out  32  ID + zero-extended o_thread_index
o_blocked_mask  out  NUM_THREADS  registered blocked set
o_idle  out  1  no eligible thread, or still in BOOT

Behaviour:
- Reset is asynchronous and active-high. It forces state=BOOT, boot counter 0, ptr=NUM_THREADS-1 (so the first issue is thread 0), blocked=0, o_issue_valid=0, o_thread_index=0, o_hartid=ID, o_idle=1.
- Reset asserted mid-operation clears everything immediately; no partial issue completes.
- States:
  - BOOT: count up each cycle; go to RUN when count == BOOT_CYCLES (BOOT_CYCLES=0 gives RUN on the first post-reset edge).
  - RUN: normal issue.
  - No other states; encodings outside these two go to BOOT.
- In BOOT, o_issue_valid=0 and i_stall is ignored.
- Eligibility, computed from the registered mask plus this cycle's block:
  - eligible[t] = i_thread_enable[t] & ~blocked[t] & ~(i_block_valid & i_block_index==t).
  - A same-cycle wake does not make a thread eligible until the next cycle.
- Blocked-mask update runs every cycle in both states, including during stall:
  - block sets the bit; wake clears it.
  - Block and wake on the same index in the same cycle: wake wins (bit ends 0); simulation assertion fires.
  - Block and wake on different indices: both apply.
- RUN with STRICT_BARREL=1, when not stalled:
  - nxt = ptr+1 mod NUM_THREADS (natural wrap); ptr<=nxt.
  - o_thread_index<=nxt; o_issue_valid<=eligible[nxt].
- RUN with STRICT_BARREL=0, when not stalled:
  - Circular search from ptr+1 through ptr, inclusive, for the first eligible thread f.
  - If found: ptr<=f, o_thread_index<=f, o_issue_valid<=1.
  - Else: ptr holds, o_issue_valid<=0, o_thread_index holds.
- i_stall=1 in RUN: ptr, o_issue_valid, o_thread_index and o_hartid all hold; only the blocked mask updates.
- o_hartid is registered in the same edge as o_thread_index: ID + {0, index}, 32-bit wrap.
- o_idle is registered: 1 in BOOT, or in RUN when eligible is all-zero.
- Latency: an enable or wake change affects the issue decision one edge later; the issue output is registered (one cycle from decision).

Decomposition:
- Package barrel_sched_pkg holds:
  - sched_state_e {BOOT, RUN};
  - thread index typedef parameterised via localparam TID_W = $clog2(NUM_THREADS).
- Sub-module rr_next_eligible: purely combinational circular priority finder.
  - Inputs: eligible mask, start ptr.
  - Outputs: found, index.
  - Used only when STRICT_BARREL=0.

Test Plan:
- NUM_THREADS=4, ID=0x100, BOOT_CYCLES=2, STRICT=1, all enabled -> o_issue_valid low for the first 3 edges after reset release, then index 0,1,2,3,0 each valid, o_hartid 0x100..0x103.
- STRICT=1, enable=4'b1011 -> sequence 0v,1v,2 bubble (valid=0, index=2),3v,0v.
- STRICT=0, enable=4'b1001 -> issues 0,3,0,3 back-to-back, no bubbles; enable=0 -> o_issue_valid=0, o_idle=1 next edge.
- STRICT=0, block thread 1 while ptr=0, all enabled -> next issue is 2 (same-cycle exclusion), o_blocked_mask=4'b0010; wake 1 -> thread 1 is issued again on the following rotation.
- i_stall high for 3 cycles during RUN with a block of thread 2 -> outputs frozen, o_blocked_mask shows 4'b0100 after the block edge, rotation resumes from the held ptr.
- Simultaneous block+wake of thread 3 -> bit 3 stays 0, assertion logged. Assert reset mid-rotation -> outputs at reset values within the same cycle (async).
